// File: rtl/dp3_cell_sched.sv
// Sequencer for the three-sequence affine-gap DP engine: walks the (i,j,k) lattice
// one cell at a time, waits for each writeback, and latches the corner score.
module dp3_cell_sched #(
  parameter int AW     = 8,
  parameter int MAXLEN = 200,
  parameter int SW     = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [AW-1:0]        len_a,
  input  logic [AW-1:0]        len_b,
  input  logic [AW-1:0]        len_c,
  output logic                 cell_valid,
  input  logic                 cell_ready,
  output logic [AW-1:0]        cell_i,
  output logic [AW-1:0]        cell_j,
  output logic [AW-1:0]        cell_k,
  output logic                 cell_boundary,
  input  logic                 wb_valid,
  input  logic signed [SW-1:0] wb_score,
  output logic                 busy,
  output logic                 done,
  output logic signed [SW-1:0] final_score,
  output logic [3*AW+1:0]      cell_count,
  output logic                 err_len,
  output logic                 err_proto
);

  localparam logic [AW-1:0] MAXL = AW'(MAXLEN);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_WB, DONE} state_t;
  state_t state;

  logic [AW-1:0] la, lb, lc;
  logic [AW-1:0] ni, nj, nk;
  logic          len_bad, k_wrap, j_wrap, last_cell;

  always_comb begin
    len_bad   = (len_a == '0) || (len_b == '0) || (len_c == '0) ||
                (len_a > MAXL) || (len_b > MAXL) || (len_c > MAXL);
    k_wrap    = (cell_k == lc);
    j_wrap    = (cell_j == lb);
    last_cell = (cell_i == la) && j_wrap && k_wrap;
    // raster order, k innermost
    nk = k_wrap ? '0 : cell_k + 1'b1;
    nj = k_wrap ? (j_wrap ? '0 : cell_j + 1'b1) : cell_j;
    ni = (k_wrap && j_wrap) ? cell_i + 1'b1 : cell_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cell_valid    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_len       <= 1'b0;
      err_proto     <= 1'b0;
      cell_boundary <= 1'b0;
      final_score   <= '0;
      cell_count    <= '0;
      cell_i        <= '0;
      cell_j        <= '0;
      cell_k        <= '0;
      la            <= '0;
      lb            <= '0;
      lc            <= '0;
    end else begin
      done    <= 1'b0;
      err_len <= 1'b0;
      case (state)
        IDLE: begin
          if (wb_valid) err_proto <= 1'b1;
          if (start) begin
            if (len_bad) begin
              err_len <= 1'b1;
            end else begin
              la            <= len_a;
              lb            <= len_b;
              lc            <= len_c;
              cell_count    <= '0;
              err_proto     <= 1'b0;
              cell_i        <= '0;
              cell_j        <= '0;
              cell_k        <= '0;
              cell_boundary <= 1'b1;
              cell_valid    <= 1'b1;
              busy          <= 1'b1;
              state         <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (abort) begin
            cell_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            if (wb_valid) err_proto <= 1'b1;
            if (cell_ready) begin
              cell_valid <= 1'b0;
              state      <= WAIT_WB;
            end
          end
        end
        WAIT_WB: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (wb_valid) begin
            cell_count <= cell_count + 1'b1;
            if (last_cell) begin
              final_score <= wb_score;
              done        <= 1'b1;
              busy        <= 1'b0;
              state       <= DONE;
            end else begin
              cell_i        <= ni;
              cell_j        <= nj;
              cell_k        <= nk;
              cell_boundary <= (ni == '0) || (nj == '0) || (nk == '0);
              cell_valid    <= 1'b1;
              state         <= ISSUE;
            end
          end
        end
        DONE: begin
          if (wb_valid) err_proto <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dp3_cell_sched.sv
// Bench for dp3_cell_sched: length-check table, lattice runs against a nested-loop
// model with random stalls/latencies, plus abort, protocol-error and reset sequences.
module tb_dp3_cell_sched;
  localparam int AW = 8, MAXLEN = 200, SW = 12;

  logic                 clk = 1'b0;
  logic                 rst, start, abort, cell_ready, wb_valid;
  logic [AW-1:0]        len_a, len_b, len_c;
  logic signed [SW-1:0] wb_score;
  logic                 cell_valid, cell_boundary, busy, done, err_len, err_proto;
  logic [AW-1:0]        cell_i, cell_j, cell_k;
  logic signed [SW-1:0] final_score;
  logic [3*AW+1:0]      cell_count;

  dp3_cell_sched #(.AW(AW), .MAXLEN(MAXLEN), .SW(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .len_a(len_a), .len_b(len_b), .len_c(len_c),
    .cell_valid(cell_valid), .cell_ready(cell_ready),
    .cell_i(cell_i), .cell_j(cell_j), .cell_k(cell_k), .cell_boundary(cell_boundary),
    .wb_valid(wb_valid), .wb_score(wb_score),
    .busy(busy), .done(done), .final_score(final_score),
    .cell_count(cell_count), .err_len(err_len), .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic signed [SW-1:0] exp_final;

  typedef struct {int la; int lb; int lc; bit ok;} lv_t;
  lv_t tbl[9];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: expected cell sequence is a plain triple loop; one cell in flight at a time.
  task automatic run(input int la, input int lb, input int lc, input bit rnd,
                     input bit idx_score, input int abort_idx);
    int ci[$], cj[$], ck[$];
    int n, tries, d;
    bit acc;
    logic signed [SW-1:0] sc;
    for (int i = 0; i <= la; i++)
      for (int j = 0; j <= lb; j++)
        for (int k = 0; k <= lc; k++) begin
          ci.push_back(i); cj.push_back(j); ck.push_back(k);
        end
    n = ci.size();
    len_a = AW'(la); len_b = AW'(lb); len_c = AW'(lc);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_err_proto", err_proto, 0);
    chk("start_count", cell_count, 0);
    for (int c = 0; c < n; c++) begin
      tries = 0;
      acc   = 1'b0;
      do begin
        chk("cell_valid", cell_valid, 1);
        chk("cell_i", cell_i, ci[c]);
        chk("cell_j", cell_j, cj[c]);
        chk("cell_k", cell_k, ck[c]);
        chk("cell_boundary", cell_boundary, (ci[c] == 0 || cj[c] == 0 || ck[c] == 0) ? 1 : 0);
        cell_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        acc = cell_ready && cell_valid;
        tick();
        cell_ready = 1'b0;
        tries++;
      end while (!acc && tries < 40);
      if (!acc) begin
        chk("accept_timeout", 0, 1);
        return;
      end
      chk("valid_drop", cell_valid, 0);
      if (c == abort_idx) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", cell_valid, 0);
        chk("abort_done", done, 0);
        chk("abort_final", final_score, exp_final);
        chk("abort_count", cell_count, c);
        wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        chk("late_wb_err_proto", err_proto, 1);
        chk("late_wb_count", cell_count, c);
        chk("late_wb_valid", cell_valid, 0);
        return;
      end
      d = rnd ? $urandom_range(0, 5) : 0;
      repeat (d) begin
        tick();
        chk("wait_valid", cell_valid, 0);
        chk("wait_busy", busy, 1);
      end
      sc = idx_score ? SW'(c) : SW'($urandom_range(0, (1 << SW) - 1));
      wb_valid = 1'b1;
      wb_score = sc;
      tick();
      wb_valid = 1'b0;
      chk("count", cell_count, c + 1);
      if (c == n - 1) begin
        chk("done", done, 1);
        chk("done_busy", busy, 0);
        chk("final_score", final_score, sc);
        chk("done_valid", cell_valid, 0);
        exp_final = sc;
        tick();
        chk("done_pulse_end", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_count", cell_count, n);
      end else begin
        chk("no_early_done", done, 0);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, cell_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err_len"}, err_len, 0);
    chk({tag, "_err_proto"}, err_proto, 0);
    chk({tag, "_boundary"}, cell_boundary, 0);
    chk({tag, "_final"}, final_score, 0);
    chk({tag, "_count"}, cell_count, 0);
    chk({tag, "_coord"}, {cell_i, cell_j, cell_k}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, 1, 1, 1'b1};
    tbl[1] = '{1, 0, 1, 1'b0};
    tbl[2] = '{MAXLEN + 1, 1, 1, 1'b0};
    tbl[3] = '{0, 1, 1, 1'b0};
    tbl[4] = '{1, 1, 0, 1'b0};
    tbl[5] = '{MAXLEN, MAXLEN, MAXLEN, 1'b1};
    tbl[6] = '{1, MAXLEN + 1, 1, 1'b0};
    tbl[7] = '{255, 1, 1, 1'b0};
    tbl[8] = '{3, 2, MAXLEN, 1'b1};

    rst = 1'b1; start = 1'b0; abort = 1'b0; cell_ready = 1'b0; wb_valid = 1'b0;
    wb_score = '0; len_a = '0; len_b = '0; len_c = '0;
    exp_final = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_reset_outputs("reset");

    run(1, 1, 1, 1'b0, 1'b1, -1);
    run(2, 3, 1, 1'b1, 1'b0, -1);

    foreach (tbl[t]) begin
      len_a = AW'(tbl[t].la); len_b = AW'(tbl[t].lb); len_c = AW'(tbl[t].lc);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk($sformatf("len%0d_err_len", t), err_len, !tbl[t].ok);
      chk($sformatf("len%0d_busy", t), busy, tbl[t].ok);
      chk($sformatf("len%0d_valid", t), cell_valid, tbl[t].ok);
      if (tbl[t].ok) begin
        chk($sformatf("len%0d_boundary", t), cell_boundary, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk($sformatf("len%0d_abort_busy", t), busy, 0);
        chk($sformatf("len%0d_abort_count", t), cell_count, 0);
      end else begin
        tick();
        chk($sformatf("len%0d_err_len_pulse", t), err_len, 0);
        chk($sformatf("len%0d_valid_later", t), cell_valid, 0);
        chk($sformatf("len%0d_busy_later", t), busy, 0);
      end
      chk($sformatf("len%0d_final", t), final_score, exp_final);
    end

    // wb_valid in IDLE, then in ISSUE before accept
    wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    chk("idle_wb_err_proto", err_proto, 1);
    chk("idle_wb_busy", busy, 0);
    len_a = 8'd1; len_b = 8'd1; len_c = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("proto_start_clear", err_proto, 0);
    wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    chk("issue_wb_err_proto", err_proto, 1);
    chk("issue_wb_valid", cell_valid, 1);
    chk("issue_wb_coord", {cell_i, cell_j, cell_k}, 0);
    chk("issue_wb_count", cell_count, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("proto_abort_busy", busy, 0);

    run(3, 3, 3, 1'b0, 1'b0, 24);
    run(3, 3, 3, 1'b1, 1'b0, -1);

    // reset while in ISSUE
    len_a = 8'd2; len_b = 8'd2; len_c = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("pre_rst_valid", cell_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("midrun_rst");
    exp_final = '0;
    run(2, 2, 2, 1'b1, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
